// File: rtl/sysarr_output_collector.sv
// Row FIFO between the systolic array and the memory side, with matrix row-order tracking.
// Define SYSARR_OUT_RELU_EN to clamp negative lanes to zero at the FIFO head.
module sysarr_output_collector #(
    parameter int N          = 4,
    parameter int DW         = 16,
    parameter int FIFO_DEPTH = 8,
    localparam int RW        = (N > 1) ? $clog2(N) : 1
) (
    input  logic            CLK,
    input  logic            nRST,
    input  logic            out_en,
    input  logic [RW-1:0]   row_out,
    input  logic [DW*N-1:0] array_output,
    input  logic            drained,
    input  logic            clear_err,
    output logic            mem_valid,
    input  logic            mem_ready,
    output logic [DW*N-1:0] mem_data,
    output logic [RW-1:0]   mem_row,
    output logic            mem_last,
    output logic            space_for_gemm,
    output logic            matrix_done,
    output logic            overflow_err,
    output logic            order_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {IDLE, COLLECT} state_t;

    state_t            r_state;
    state_t            w_nextState;
    logic [DW*N-1:0]   r_data [FIFO_DEPTH];
    logic [RW-1:0]     r_row  [FIFO_DEPTH];
    logic              r_last [FIFO_DEPTH];
    logic [AW-1:0]     r_wrPtr;
    logic [AW-1:0]     r_rdPtr;
    logic [CW-1:0]     r_count;
    logic [RW-1:0]     r_expRow;
    logic [RW-1:0]     w_nextExpRow;
    logic              r_overflowErr;
    logic              r_orderErr;
    logic              r_matrixDone;
    logic              w_push;
    logic              w_pop;
    logic              w_lastRow;
    logic              w_orderEvt;
    logic              w_overflowEvt;
    logic [DW*N-1:0]   w_headData;

    assign w_pop         = (r_count != '0) && mem_ready;
    assign w_push        = out_en && ((r_count < CW'(FIFO_DEPTH)) || w_pop);
    assign w_overflowEvt = out_en && !w_push;
    assign w_lastRow     = (r_expRow == RW'(N - 1));

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state  <= IDLE;
            r_expRow <= '0;
        end else begin
            r_state  <= w_nextState;
            r_expRow <= w_nextExpRow;
        end
    end

    // A final push arriving together with drained completes the matrix rather than cutting it off.
    always_comb begin
        w_nextState  = r_state;
        w_nextExpRow = r_expRow;
        w_orderEvt   = 1'b0;
        if (w_push) begin
            w_orderEvt = (row_out != r_expRow);
            if (w_lastRow) begin
                w_nextExpRow = '0;
                w_nextState  = IDLE;
            end else begin
                w_nextExpRow = r_expRow + RW'(1);
                w_nextState  = COLLECT;
            end
        end
        if (drained && (r_state == COLLECT) && !(w_push && w_lastRow)) begin
            w_orderEvt   = 1'b1;
            w_nextExpRow = '0;
            w_nextState  = IDLE;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_data[i] <= '0;
                r_row[i]  <= '0;
                r_last[i] <= 1'b0;
            end
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_data[r_wrPtr] <= array_output;
                r_row[r_wrPtr]  <= row_out;
                r_last[r_wrPtr] <= w_lastRow;
                r_wrPtr         <= r_wrPtr + AW'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // An error event in the same cycle as clear_err keeps the flag set.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_overflowErr <= 1'b0;
            r_orderErr    <= 1'b0;
            r_matrixDone  <= 1'b0;
        end else begin
            r_overflowErr <= (r_overflowErr && !clear_err) || w_overflowEvt;
            r_orderErr    <= (r_orderErr && !clear_err) || w_orderEvt;
            r_matrixDone  <= w_pop && r_last[r_rdPtr];
        end
    end

    always_comb begin
        w_headData = r_data[r_rdPtr];
`ifdef SYSARR_OUT_RELU_EN
        for (int k = 0; k < N; k++) begin
            if (w_headData[DW*k + DW - 1]) begin
                w_headData[DW*k +: DW] = '0;
            end
        end
`endif
    end

    assign mem_valid      = (r_count != '0);
    assign mem_data       = w_headData;
    assign mem_row        = r_row[r_rdPtr];
    assign mem_last       = r_last[r_rdPtr];
    assign space_for_gemm = ((CW'(FIFO_DEPTH) - r_count) >= CW'(N));
    assign matrix_done    = r_matrixDone;
    assign overflow_err   = r_overflowErr;
    assign order_err      = r_orderErr;

endmodule

// File: tb/tb_sysarr_output_collector.sv
// Scoreboard bench for sysarr_output_collector (N=4, DW=16, FIFO_DEPTH=8).
// Expected rows are queued at stimulus time; a negedge monitor pops and compares on each handshake.
module tb_sysarr_output_collector;

    typedef struct packed {
        logic        last;
        logic [1:0]  row;
        logic [63:0] data;
    } entry_t;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        out_en = 1'b0;
    logic [1:0]  row_out = '0;
    logic [63:0] array_output = '0;
    logic        drained = 1'b0;
    logic        clear_err = 1'b0;
    logic        mem_valid;
    logic        mem_ready = 1'b0;
    logic [63:0] mem_data;
    logic [1:0]  mem_row;
    logic        mem_last;
    logic        space_for_gemm;
    logic        matrix_done;
    logic        overflow_err;
    logic        order_err;

    entry_t expQ[$];
    int     numChecks = 0;
    int     numErrors = 0;
    logic   expDone = 1'b0;

    sysarr_output_collector #(.N(4), .DW(16), .FIFO_DEPTH(8)) dut (
        .CLK(CLK), .nRST(nRST), .out_en(out_en), .row_out(row_out),
        .array_output(array_output), .drained(drained), .clear_err(clear_err),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_data(mem_data),
        .mem_row(mem_row), .mem_last(mem_last), .space_for_gemm(space_for_gemm),
        .matrix_done(matrix_done), .overflow_err(overflow_err), .order_err(order_err)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        numChecks++;
        if (actual !== expected) begin
            numErrors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, then return 1 time unit after the capturing edge.
    task automatic applyStimulus(input logic en, input logic [1:0] row, input logic [63:0] data,
                                 input logic drn, input logic clr);
        out_en       = en;
        row_out      = row;
        array_output = data;
        drained      = drn;
        clear_err    = clr;
        @(posedge CLK);
        #1;
        out_en    = 1'b0;
        drained   = 1'b0;
        clear_err = 1'b0;
    endtask

    task automatic sendRow(input logic [1:0] row, input logic [63:0] data, input logic [63:0] expData,
                           input logic expLast, input logic accept, input logic drn, input logic clr);
        entry_t e;
        if (accept) begin
            e.last = expLast;
            e.row  = row;
            e.data = expData;
            expQ.push_back(e);
        end
        applyStimulus(1'b1, row, data, drn, clr);
    endtask

    task automatic sendMatrix(input logic [15:0] tag);
        for (int r = 0; r < 4; r++) begin
            sendRow(2'(r), {tag, 16'(r), 16'h1234, 16'h0ABC}, {tag, 16'(r), 16'h1234, 16'h0ABC},
                    (r == 3), 1'b1, 1'b0, 1'b0);
        end
    endtask

    task automatic waitDrain(input string name);
        for (int i = 0; i < 40 && mem_valid; i++) begin
            @(posedge CLK);
            #1;
        end
        applyStimulus(1'b0, 2'd0, 64'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 2'd0, 64'd0, 1'b0, 1'b0);
        checkOutput({name, "_empty"}, 64'(mem_valid), 64'd0);
        checkOutput({name, "_scoreboard"}, 64'(expQ.size()), 64'd0);
    endtask

    // Monitor: checks matrix_done every cycle and compares each popped head against the scoreboard.
    always @(negedge CLK) begin
        entry_t e;
        if (!nRST) begin
            expDone = 1'b0;
        end else begin
            checkOutput("matrix_done", 64'(matrix_done), 64'(expDone));
            expDone = 1'b0;
            if (mem_valid && mem_ready) begin
                if (expQ.size() == 0) begin
                    numChecks++;
                    numErrors++;
                    $display("[TB] FAIL unexpected_pop: got row %0d data %h expected no entry", mem_row, mem_data);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("pop_data", mem_data, e.data);
                    checkOutput("pop_row", 64'(mem_row), 64'(e.row));
                    checkOutput("pop_last", 64'(mem_last), 64'(e.last));
                    expDone = e.last;
                end
            end
        end
    end

    initial begin
        // Reset state
        #12;
        checkOutput("rst_valid", 64'(mem_valid), 64'd0);
        checkOutput("rst_space", 64'(space_for_gemm), 64'd1);
        checkOutput("rst_ovf", 64'(overflow_err), 64'd0);
        checkOutput("rst_ord", 64'(order_err), 64'd0);
        checkOutput("rst_done", 64'(matrix_done), 64'd0);
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        applyStimulus(1'b0, 2'd0, 64'd0, 1'b0, 1'b0);
        checkOutput("post_rst_valid", 64'(mem_valid), 64'd0);

        // One full matrix streamed straight through
        mem_ready = 1'b1;
        sendMatrix(16'h0100);
        waitDrain("t2");

        // Fill to capacity, then drop a 9th row
        mem_ready = 1'b0;
        sendMatrix(16'h0200);
        sendMatrix(16'h0300);
        checkOutput("full_valid", 64'(mem_valid), 64'd1);
        checkOutput("full_space", 64'(space_for_gemm), 64'd0);
        checkOutput("full_ovf_before", 64'(overflow_err), 64'd0);
        sendRow(2'd0, 64'h0400_0000_DEAD_BEEF, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("drop_ovf", 64'(overflow_err), 64'd1);
        checkOutput("drop_ord", 64'(order_err), 64'd0);
        mem_ready = 1'b1;
        waitDrain("t3a");
        applyStimulus(1'b0, 2'd0, 64'd0, 1'b0, 1'b1);
        checkOutput("ovf_cleared", 64'(overflow_err), 64'd0);

        // Full FIFO with a simultaneous pop accepts the push
        mem_ready = 1'b0;
        sendMatrix(16'h0500);
        sendMatrix(16'h0600);
        mem_ready = 1'b1;
        sendRow(2'd0, 64'h0700_0000_1111_2222, 64'h0700_0000_1111_2222, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("fullpop_ovf", 64'(overflow_err), 64'd0);
        sendRow(2'd1, 64'h0700_0001_1111_2222, 64'h0700_0001_1111_2222, 1'b0, 1'b1, 1'b0, 1'b0);
        sendRow(2'd2, 64'h0700_0002_1111_2222, 64'h0700_0002_1111_2222, 1'b0, 1'b1, 1'b0, 1'b0);
        sendRow(2'd3, 64'h0700_0003_1111_2222, 64'h0700_0003_1111_2222, 1'b1, 1'b1, 1'b0, 1'b0);
        waitDrain("t3b");
        checkOutput("t3b_ovf", 64'(overflow_err), 64'd0);

        // space_for_gemm threshold at exactly N free entries
        mem_ready = 1'b0;
        for (int r = 0; r < 4; r++) begin
            sendRow(2'(r), 64'h0800_0000_0000_0000 | 64'(r), 64'h0800_0000_0000_0000 | 64'(r),
                    (r == 3), 1'b1, 1'b0, 1'b0);
        end
        checkOutput("space_4", 64'(space_for_gemm), 64'd1);
        sendRow(2'd0, 64'h0900_0000_0000_0000, 64'h0900_0000_0000_0000, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("space_5", 64'(space_for_gemm), 64'd0);
        mem_ready = 1'b1;
        applyStimulus(1'b0, 2'd0, 64'd0, 1'b0, 1'b0);
        mem_ready = 1'b0;
        checkOutput("space_after_pop", 64'(space_for_gemm), 64'd1);
        mem_ready = 1'b1;
        sendRow(2'd1, 64'h0900_0000_0000_0001, 64'h0900_0000_0000_0001, 1'b0, 1'b1, 1'b0, 1'b0);
        sendRow(2'd2, 64'h0900_0000_0000_0002, 64'h0900_0000_0000_0002, 1'b0, 1'b1, 1'b0, 1'b0);
        sendRow(2'd3, 64'h0900_0000_0000_0003, 64'h0900_0000_0000_0003, 1'b1, 1'b1, 1'b0, 1'b0);
        waitDrain("t4");

        // Row-order errors, clear, drained cut-off, drained coinciding with the final row
        sendRow(2'd0, 64'h0A00_0000_0000_0000, 64'h0A00_0000_0000_0000, 1'b0, 1'b1, 1'b0, 1'b0);
        sendRow(2'd2, 64'h0A00_0000_0000_0002, 64'h0A00_0000_0000_0002, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("ord_skip", 64'(order_err), 64'd1);
        applyStimulus(1'b0, 2'd0, 64'd0, 1'b0, 1'b1);
        checkOutput("ord_clear1", 64'(order_err), 64'd0);
        applyStimulus(1'b0, 2'd0, 64'd0, 1'b1, 1'b0);
        checkOutput("ord_drained1", 64'(order_err), 64'd1);
        applyStimulus(1'b0, 2'd0, 64'd0, 1'b0, 1'b1);
        checkOutput("ord_clear2", 64'(order_err), 64'd0);
        sendRow(2'd0, 64'h0B00_0000_0000_0000, 64'h0B00_0000_0000_0000, 1'b0, 1'b1, 1'b0, 1'b0);
        sendRow(2'd1, 64'h0B00_0000_0000_0001, 64'h0B00_0000_0000_0001, 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 2'd0, 64'd0, 1'b1, 1'b0);
        checkOutput("ord_drained2", 64'(order_err), 64'd1);
        applyStimulus(1'b0, 2'd0, 64'd0, 1'b0, 1'b1);
        checkOutput("ord_clear3", 64'(order_err), 64'd0);
        sendMatrix(16'h0C00);
        checkOutput("ord_restart", 64'(order_err), 64'd0);
        sendRow(2'd0, 64'h0D00_0000_0000_0000, 64'h0D00_0000_0000_0000, 1'b0, 1'b1, 1'b0, 1'b0);
        sendRow(2'd1, 64'h0D00_0000_0000_0001, 64'h0D00_0000_0000_0001, 1'b0, 1'b1, 1'b0, 1'b0);
        sendRow(2'd2, 64'h0D00_0000_0000_0002, 64'h0D00_0000_0000_0002, 1'b0, 1'b1, 1'b0, 1'b0);
        sendRow(2'd3, 64'h0D00_0000_0000_0003, 64'h0D00_0000_0000_0003, 1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput("ord_final_drained", 64'(order_err), 64'd0);
        sendRow(2'd1, 64'h0E00_0000_0000_0001, 64'h0E00_0000_0000_0001, 1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("ord_set_wins", 64'(order_err), 64'd1);
        sendRow(2'd1, 64'h0E00_0000_0000_0011, 64'h0E00_0000_0000_0011, 1'b0, 1'b1, 1'b0, 1'b0);
        sendRow(2'd2, 64'h0E00_0000_0000_0002, 64'h0E00_0000_0000_0002, 1'b0, 1'b1, 1'b0, 1'b0);
        sendRow(2'd3, 64'h0E00_0000_0000_0003, 64'h0E00_0000_0000_0003, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 2'd0, 64'd0, 1'b0, 1'b1);
        checkOutput("ord_clear4", 64'(order_err), 64'd0);
        waitDrain("t5");

        // Sign handling at the head
`ifdef SYSARR_OUT_RELU_EN
        sendRow(2'd0, 64'h7FFF_8000_0001_8001, 64'h7FFF_0000_0001_0000, 1'b0, 1'b1, 1'b0, 1'b0);
`else
        sendRow(2'd0, 64'h7FFF_8000_0001_8001, 64'h7FFF_8000_0001_8001, 1'b0, 1'b1, 1'b0, 1'b0);
`endif
        sendRow(2'd1, 64'h0F00_0000_0000_0001, 64'h0F00_0000_0000_0001, 1'b0, 1'b1, 1'b0, 1'b0);
        sendRow(2'd2, 64'h0F00_0000_0000_0002, 64'h0F00_0000_0000_0002, 1'b0, 1'b1, 1'b0, 1'b0);
        sendRow(2'd3, 64'h0F00_0000_0000_0003, 64'h0F00_0000_0000_0003, 1'b1, 1'b1, 1'b0, 1'b0);
        waitDrain("t6");

        // Reset mid-matrix discards buffered rows and restarts row tracking
        mem_ready = 1'b0;
        applyStimulus(1'b1, 2'd0, 64'h1000_0000_0000_0000, 1'b0, 1'b0);
        applyStimulus(1'b1, 2'd1, 64'h1000_0000_0000_0001, 1'b0, 1'b0);
        checkOutput("mid_valid", 64'(mem_valid), 64'd1);
        nRST = 1'b0;
        #2;
        checkOutput("mid_rst_valid", 64'(mem_valid), 64'd0);
        checkOutput("mid_rst_space", 64'(space_for_gemm), 64'd1);
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        mem_ready = 1'b1;
        sendMatrix(16'h1100);
        checkOutput("mid_restart_ord", 64'(order_err), 64'd0);
        waitDrain("t7");

        $display("[TB] Result: errors=%0d of %0d checks", numErrors, numChecks);
        $finish;
    end

endmodule
